// File: rtl/seg_scan_if.sv
// -----------------------------------------------------------------------------
// seg_scan_if
//   Display bus between the instruction editor and the seven-segment scanner.
//   Signals:
//     seg1..seg6 [5:0] : display codes, seg1 is the leftmost digit
//     twinkle    [7:0] : blink mask, bit i blinks digit i+1 (bits 7:6 unused)
//     an         [5:0] : digit enables, active low, an[0] is digit 1
//     seg        [7:0] : segment lines, active low, {dp,g,f,e,d,c,b,a}
//   Modports:
//     master : code/mask producer, observes the display lines
//     slave  : the scanner, consumes codes/mask and drives the display lines
// -----------------------------------------------------------------------------
interface seg_scan_if;
   logic [5:0] seg1;
   logic [5:0] seg2;
   logic [5:0] seg3;
   logic [5:0] seg4;
   logic [5:0] seg5;
   logic [5:0] seg6;
   logic [7:0] twinkle;
   logic [5:0] an;
   logic [7:0] seg;

   modport master (
      output seg1, seg2, seg3, seg4, seg5, seg6, twinkle,
      input  an, seg
   );

   modport slave (
      input  seg1, seg2, seg3, seg4, seg5, seg6, twinkle,
      output an, seg
   );
endinterface

// File: rtl/seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan
//   Six-digit multiplexed common-anode seven-segment scanner. Each digit owns a
//   slot of SCAN_DIV cycles: one dead-time cycle (all off) followed by
//   SCAN_DIV-1 cycles with the digit driven. The code and blink bit for a digit
//   are sampled once, at the start of its slot.
//   Optional blink logic is built when the macro SEG_SCAN_BLINK_EN is defined;
//   otherwise twinkle is ignored and BLINK_DIV is unused.
//   Parameters:
//     SCAN_DIV  : cycles per digit slot (>= 2)
//     BLINK_DIV : cycles per blink half-period (>= 1)
//   Ports:
//     clk   : system clock
//     rst_n : asynchronous active-low reset
//     bus   : seg_scan_if.slave (codes/mask in, an/seg out, all active low out)
// -----------------------------------------------------------------------------
module seg_scan #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic        clk,
   input  logic        rst_n,
   seg_scan_if.slave   bus
);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   logic [SW-1:0] r_scan_cnt;
   logic [2:0]    r_idx;
   logic [5:0]    r_an;
   logic [7:0]    r_seg;

   logic [5:0]    w_code;
   logic [6:0]    w_pat;
   logic [5:0]    w_an_sel;
   logic          w_blank;

   // Active-high {g..a} pattern for a display code; unlisted codes are blank.
   function automatic logic [6:0] decode(input logic [5:0] code);
      logic [6:0] p;
      p = 7'h00;
      case (code)
         6'd0:  p = 7'h3F;
         6'd1:  p = 7'h06;
         6'd2:  p = 7'h5B;
         6'd3:  p = 7'h4F;
         6'd4:  p = 7'h66;
         6'd5:  p = 7'h6D;
         6'd6:  p = 7'h7D;
         6'd7:  p = 7'h07;
         6'd8:  p = 7'h7F;
         6'd9:  p = 7'h6F;
         6'd11: p = 7'h77;
         6'd12: p = 7'h7C;
         6'd13: p = 7'h39;
         6'd14: p = 7'h5E;
         6'd15: p = 7'h79;
         6'd16: p = 7'h71;
         6'd17: p = 7'h40;
         6'd26: p = 7'h73;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   always_comb begin
      w_code = bus.seg1;
      case (r_idx)
         3'd0: w_code = bus.seg1;
         3'd1: w_code = bus.seg2;
         3'd2: w_code = bus.seg3;
         3'd3: w_code = bus.seg4;
         3'd4: w_code = bus.seg5;
         3'd5: w_code = bus.seg6;
         default: w_code = bus.seg1;
      endcase
   end

   assign w_pat = decode(w_code);

   // Only the enable of the current digit goes low.
   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_an
         assign w_an_sel[gi] = (r_idx != 3'(gi));
      end
   endgenerate

`ifdef SEG_SCAN_BLINK_EN
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [BW-1:0] r_blink_cnt;
   logic          r_blink_on;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (r_blink_cnt == BLINK_LAST) begin
         r_blink_cnt <= '0;
         r_blink_on  <= ~r_blink_on;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   // Uses the phase as it stands at the slot-start edge, so a toggle on the
   // same edge as a slot end first shows at the following slot.
   assign w_blank = bus.twinkle[r_idx] & ~r_blink_on;
`else
   logic w_unused;
   assign w_unused = ^{bus.twinkle, BLINK_DIV[0]};
   assign w_blank  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_cnt <= '0;
         r_idx      <= 3'd0;
         r_an       <= 6'h3F;
         r_seg      <= 8'hFF;
      end else if (r_scan_cnt == SCAN_LAST) begin
         // Slot end: blank everything for one cycle and move to the next digit.
         r_scan_cnt <= '0;
         r_idx      <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
         r_an       <= 6'h3F;
         r_seg      <= 8'hFF;
      end else begin
         r_scan_cnt <= r_scan_cnt + 1'b1;
         if (r_scan_cnt == '0) begin
            // Slot start: the only point where inputs are sampled.
            r_an  <= w_an_sel;
            r_seg <= w_blank ? 8'hFF : {1'b1, ~w_pat};
         end
      end
   end

   assign bus.an  = r_an;
   assign bus.seg = r_seg;
endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;
   localparam int SD = 4;
   localparam int BD = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   seg_scan_if bus();

   seg_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         e      = 0;        // edges since reset release
   bit         blink_en;
   logic [7:0] tbl [64];
   logic [5:0] exp_an;
   logic [7:0] exp_seg;

   function automatic logic [5:0] code_of(input int d);
      case (d)
         0: return bus.seg1;
         1: return bus.seg2;
         2: return bus.seg3;
         3: return bus.seg4;
         4: return bus.seg5;
         default: return bus.seg6;
      endcase
   endfunction

   task automatic set_code(input int d, input logic [5:0] c);
      case (d)
         0: bus.seg1 = c;
         1: bus.seg2 = c;
         2: bus.seg3 = c;
         3: bus.seg4 = c;
         4: bus.seg5 = c;
         default: bus.seg6 = c;
      endcase
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s edge=%0d got %h want %h", tag, e, got, want);
      end
   endtask

   // One clock: model the edge from the rules, then sample just after it.
   task automatic step();
      int  ph;
      int  d;
      bit  blank;
      @(posedge clk);
      ph = e % SD;
      d  = (e / SD) % 6;
      if (ph == 0) begin
         exp_an  = ~(6'(1) << d);
         blank   = blink_en && bus.twinkle[d] && (((e / BD) % 2) == 1);
         exp_seg = blank ? 8'hFF : tbl[code_of(d)];
      end else if (ph == SD - 1) begin
         exp_an  = 6'h3F;
         exp_seg = 8'hFF;
      end
      e++;
      #1;
      chk("an",  {2'b00, bus.an}, {2'b00, exp_an});
      chk("seg", bus.seg, exp_seg);
   endtask

   task automatic goto_slot_start(input int d);
      int guard = 0;
      while (!((e % SD == 0) && ((e / SD) % 6 == d)) && guard < 100) begin
         step();
         guard++;
      end
   endtask

   initial begin
      int guard;
`ifdef SEG_SCAN_BLINK_EN
      blink_en = 1'b1;
`else
      blink_en = 1'b0;
`endif
      for (int i = 0; i < 64; i++) tbl[i] = 8'hFF;
      tbl[0]  = ~8'h3F; tbl[1]  = ~8'h06; tbl[2]  = ~8'h5B; tbl[3]  = ~8'h4F;
      tbl[4]  = ~8'h66; tbl[5]  = ~8'h6D; tbl[6]  = ~8'h7D; tbl[7]  = ~8'h07;
      tbl[8]  = ~8'h7F; tbl[9]  = ~8'h6F; tbl[11] = ~8'h77; tbl[12] = ~8'h7C;
      tbl[13] = ~8'h39; tbl[14] = ~8'h5E; tbl[15] = ~8'h79; tbl[16] = ~8'h71;
      tbl[17] = ~8'h40; tbl[26] = ~8'h73;

      bus.seg1 = 6'd1; bus.seg2 = 6'd2; bus.seg3 = 6'd3;
      bus.seg4 = 6'd4; bus.seg5 = 6'd5; bus.seg6 = 6'd6;
      bus.twinkle = 8'h00;

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_an",  {2'b00, bus.an}, 8'h3F);
      chk("rst_seg", bus.seg, 8'hFF);
      @(negedge clk);
      rst_n = 1'b1;
      e = 0; exp_an = 6'h3F; exp_seg = 8'hFF;
      #1;
      chk("rel_an", {2'b00, bus.an}, 8'h3F);

      // Basic scan: two full frames
      repeat (2 * 6 * SD) step();

      // Decode: 0 and P
      bus.seg3 = 6'd0; bus.seg4 = 6'd26;
      goto_slot_start(0);
      repeat (6 * SD) step();
      // Letters 11..16
      for (int i = 0; i < 6; i++) set_code(i, 6'(11 + i));
      goto_slot_start(0);
      repeat (6 * SD) step();
      // Blanks and symbol
      bus.seg1 = 6'd10; bus.seg2 = 6'd18; bus.seg3 = 6'd63;
      bus.seg4 = 6'd17; bus.seg5 = 6'd9;  bus.seg6 = 6'd7;
      goto_slot_start(0);
      repeat (6 * SD) step();

      // Blink on digits 5 and 6
      bus.twinkle = 8'h30;
      repeat (8 * 6 * SD) step();

      // Upper twinkle bits only
      bus.twinkle = 8'hC0;
      repeat (4 * 6 * SD) step();
      bus.twinkle = 8'h00;

      // Mid-slot change of seg1
      bus.seg1 = 6'd1;
      goto_slot_start(0);
      step(); step();
      bus.seg1 = 6'd8;
      step();
      chk("mid_hold", bus.seg, 8'hF9);
      goto_slot_start(0);
      step();
      chk("mid_new", bus.seg, 8'h80);

      // Reset while digit 4 is lit, between edges
      guard = 0;
      while (!(((e - 1) % SD == 1) && (((e - 1) / SD) % 6 == 3)) && guard < 100) begin
         step();
         guard++;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_an",  {2'b00, bus.an}, 8'h3F);
      chk("mrst_seg", bus.seg, 8'hFF);
      @(posedge clk); #1;
      chk("mrst_hold", {2'b00, bus.an}, 8'h3F);
      @(negedge clk);
      rst_n = 1'b1;
      e = 0; exp_an = 6'h3F; exp_seg = 8'hFF;
      step();
      chk("mrst_first_an", {2'b00, bus.an}, 8'h3E);

      // Randomized traffic with mid-slot changes and blink masks
      repeat (600) begin
         if ($urandom_range(0, 3) == 0)
            set_code(int'($urandom_range(0, 5)), 6'($urandom_range(0, 63)));
         if ($urandom_range(0, 15) == 0)
            bus.twinkle = 8'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
